// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants, bit-period helper.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_e;

    function automatic int cycles_per_bit(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: runs 0..CYCLES-1, tick is high on the wrap cycle.
// Synchronous clear re-phases the counter to the start of a frame.
module uart_baud_tick #(
    parameter int CYCLES = 1250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr || tick) cnt <= '0;
        else                       cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx8.sv
// 8-bit UART transmitter, LSB first, start/data/[parity]/stop, registered outputs.
// Define UART_TX_PARITY_EN for an 11-bit frame with parity sense PARITY_ODD.
module uart_tx8
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] txIn,
    output logic       txOut,
    output logic       txBusy,
    output logic       txDone
);
    localparam int CYCLES_PER_BIT = cycles_per_bit(CLOCK_RATE, BAUD_RATE);

    tx_state_e                 state, state_nx;
    logic [UART_DATA_BITS-1:0] shift, shift_nx;
    logic [2:0]                idx, idx_nx;
    logic                      out_nx, busy_nx, done_nx;
    logic                      clr, tick;

`ifdef UART_TX_PARITY_EN
    logic par, par_nx;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    uart_baud_tick #(.CYCLES(CYCLES_PER_BIT)) u_baud (
        .clk   (clk),
        .rst_n (rstN),
        .clr   (clr),
        .tick  (tick)
    );

    // Outputs are computed one cycle early so they register alongside the state.
    always_comb begin
        state_nx = state;
        shift_nx = shift;
        idx_nx   = idx;
        out_nx   = txOut;
        busy_nx  = txBusy;
        done_nx  = 1'b0;
        clr      = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nx   = par;
`endif
        case (state)
            IDLE: begin
                out_nx  = 1'b1;
                busy_nx = 1'b0;
                if (txEn && txStart) begin
                    state_nx = START;
                    shift_nx = txIn;
                    idx_nx   = 3'd0;
                    clr      = 1'b1;
                    out_nx   = 1'b0;
                    busy_nx  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_nx   = (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_nx = DATA;
                    out_nx   = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_nx = shift >> 1;
                    idx_nx   = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
                    par_nx   = par ^ shift[0];
`endif
                    if (idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_nx = PARITY;
                        out_nx   = par ^ shift[0];
`else
                        state_nx = STOP;
                        out_nx   = 1'b1;
`endif
                    end else begin
                        out_nx = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_nx = STOP;
                    out_nx   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_nx = IDLE;
                    out_nx   = 1'b1;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state  <= IDLE;
            shift  <= '0;
            idx    <= '0;
            txOut  <= 1'b1;
            txBusy <= 1'b0;
            txDone <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            shift  <= shift_nx;
            idx    <= idx_nx;
            txOut  <= out_nx;
            txBusy <= busy_nx;
            txDone <= done_nx;
`ifdef UART_TX_PARITY_EN
            par    <= par_nx;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx8.sv
// Bench for uart_tx8: a frame-level model checked every cycle, plus directed literal checks.
// Define UART_TX_PARITY_EN to exercise the 11-bit frame variant.
`timescale 1ns/1ps
module tb_uart_tx8;
    localparam int P             = 1250;
    localparam int TB_PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int NB       = 11;
    localparam int FRAME    = 13750;
    localparam logic [10:0] D5_SEQ = (TB_PARITY_ODD != 0) ? 11'b10110101010 : 11'b11110101010;
`else
    localparam int NB       = 10;
    localparam int FRAME    = 12500;
    localparam logic [10:0] D5_SEQ = 11'b11110101010;
`endif

    logic       clk = 1'b0, rstN = 1'b0, txEn = 1'b0, txStart = 1'b0;
    logic [7:0] txIn = 8'h00;
    logic       txOut, txBusy, txDone;

    int tests = 0, fails = 0, cyc = 0;
    int busy_cnt = 0, done_cnt = 0, hi_run = 0, last_run = 0;

    uart_tx8 #(.CLOCK_RATE(12000000), .BAUD_RATE(9600), .PARITY_ODD(TB_PARITY_ODD)) dut (
        .clk(clk), .rstN(rstN), .txEn(txEn), .txStart(txStart), .txIn(txIn),
        .txOut(txOut), .txBusy(txBusy), .txDone(txDone)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame model: bit k of the frame is on the line for cycles k*P..k*P+P-1 after acceptance.
    bit          m_valid = 1'b0, m_active = 1'b0;
    int          m_age = 0;
    logic [10:0] m_frame = '1;
    logic        e_out, e_busy, e_done;

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = (^d) ^ (TB_PARITY_ODD != 0);
`endif
        return f;
    endfunction

    always @(posedge clk) begin
        if (!rstN) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
        end else if ((!m_active || m_age >= NB * P) && txEn && txStart) begin
            m_active = 1'b1;
            m_age    = 0;
            m_frame  = frame_of(txIn);
        end else if (m_active) begin
            m_age++;
            if (m_age > NB * P) m_active = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            if (!m_active)           {e_out, e_busy, e_done} = 3'b100;
            else if (m_age < NB * P) {e_out, e_busy, e_done} = {m_frame[m_age / P], 2'b10};
            else                     {e_out, e_busy, e_done} = 3'b101;
            check("model_txOut", txOut, e_out);
            check("model_txBusy", txBusy, e_busy);
            check("model_txDone", txDone, e_done);
        end
    end

    always @(negedge clk) begin
        if (rstN) begin
            if (txBusy === 1'b1) busy_cnt++;
            if (txDone === 1'b1) done_cnt++;
            if (txOut === 1'b1) hi_run++;
            else begin
                if (hi_run > 0) last_run = hi_run;
                hi_run = 0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns the edge count of the accepting edge.
    task automatic start_frame(input logic [7:0] d, output int acc);
        txIn    = d;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        acc     = cyc;
    endtask

    task automatic wait_done(input string name, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (txDone === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            tests++;
            fails++;
            $display("FAIL %s: no txDone within %0d cycles", name, limit);
        end
    endtask

    int          acc, acc2, at, d0;
    logic [10:0] seq;

    initial begin
        // Reset and idle
        cycles(5);
        check("reset_txOut", txOut, 1'b1);
        check("reset_txBusy", txBusy, 1'b0);
        check("reset_txDone", txDone, 1'b0);
        rstN = 1'b1;
        txEn = 1'b1;
        cycles(100);
        check("idle_txOut", txOut, 1'b1);
        check("idle_txBusy", txBusy, 1'b0);

        // 8'hD5: sample the middle of every bit period
        busy_cnt = 0;
        start_frame(8'hD5, acc);
        seq = D5_SEQ;
        cycles(P / 2);
        check("d5_bit0", txOut, seq[0]);
        for (int k = 1; k < NB; k++) begin
            cycles(P);
            check($sformatf("d5_bit%0d", k), txOut, seq[k]);
        end
        wait_done("d5_done", 2 * P, at);
        check("d5_done_latency", at - acc, FRAME);
        check("d5_busy_cycles", busy_cnt, FRAME);

        // Back-to-back 8'h00 then 8'hFF, second request in the txDone cycle
        cycles(10);
        start_frame(8'h00, acc);
        wait_done("b2b_done0", FRAME + 10, at);
        check("b2b_done0_latency", at - acc, FRAME);
        start_frame(8'hFF, acc2);
        check("b2b_accept_gap", acc2 - acc, FRAME + 1);
        cycles(2);
        check("b2b_high_gap", last_run, P + 1);
        wait_done("b2b_done1", FRAME + 10, at);
        check("b2b_done1_latency", at - acc2, FRAME);

        // Mid-frame txStart/txIn changes and txEn drop are ignored
        cycles(10);
        d0 = done_cnt;
        start_frame(8'hA3, acc);
        cycles(1000);
        txIn    = 8'h5C;
        txStart = 1'b1;
        cycles(3);
        txStart = 1'b0;
        cycles(1000);
        txEn    = 1'b0;
        txStart = 1'b1;
        wait_done("busy_done", FRAME, at);
        check("busy_done_latency", at - acc, FRAME);
        cycles(50);
        check("en_off_txBusy", txBusy, 1'b0);
        check("en_off_txOut", txOut, 1'b1);
        check("busy_single_frame", done_cnt - d0, 1);
        txStart = 1'b0;
        txEn    = 1'b1;
        cycles(5);

        // Reset mid-frame truncates without txDone
        d0 = done_cnt;
        start_frame(8'h3C, acc);
        cycles(4999);
        rstN = 1'b0;
        @(negedge clk);
        check("rst_mid_txOut", txOut, 1'b1);
        check("rst_mid_txBusy", txBusy, 1'b0);
        check("rst_mid_txDone", txDone, 1'b0);
        rstN = 1'b1;
        cycles(8000);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_idle_busy", txBusy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
